// File: rtl/energy_detector_pkg.sv
// energy_detector_pkg: shared state encoding, default sizes and saturating add.
package energy_detector_pkg;

    typedef enum logic [1:0] {NOISE, SIG, DRAIN, CMP} state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WIN_LOG2 = 6;
    localparam int PROD_W       = 2 * DEF_DATA_W + 1;
    localparam int N            = 1 << DEF_WIN_LOG2;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'(1) << w) - 65'(1);
        return (s > m) ? m[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/energy_detector_square_mag.sv
// square_mag: registered |x|^2 = I*I + Q*Q with valid and phase tag carried alongside.
module square_mag
    import energy_detector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic                     i_tag,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    output logic                     o_valid,
    output logic                     o_tag,
    output logic [2*DATA_W:0]        o_prod
);

    logic signed [2*DATA_W-1:0] w_rr;
    logic signed [2*DATA_W-1:0] w_ii;
    logic [2*DATA_W:0]          w_sum;

    // squares are non-negative, so zero-extension before the add is exact
    assign w_rr  = i_re * i_re;
    assign w_ii  = i_im * i_im;
    assign w_sum = {1'b0, w_rr} + {1'b0, w_ii};

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_tag   <= 1'b0;
            o_prod  <= '0;
        end else begin
            o_valid <= i_valid;
            o_tag   <= i_tag;
            o_prod  <= w_sum;
        end
    end

endmodule

// File: rtl/energy_detector.sv
// energy_detector: alternating noise/signal window energy accumulation with
// a fixed-point threshold decision per round.
module energy_detector
    import energy_detector_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = 32,
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int THR_W    = 12,
    parameter int THR_FRAC = 4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample_real,
    input  logic [DATA_W-1:0] sample_imag,
    input  logic [THR_W-1:0]  thres,
    input  logic              hold_noise,
    output logic [ACC_W-1:0]  signal_energy,
    output logic [ACC_W-1:0]  noise_energy,
    output logic              detect,
    output logic              result_valid,
    output logic              busy
);

    localparam int PW = 2 * DATA_W + 1;
    localparam int CW = ACC_W + THR_W + 1;

    state_t              r_state;
    state_t              w_next;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [ACC_W-1:0]    r_noise_acc;
    logic [ACC_W-1:0]    r_sig_acc;
    logic [ACC_W-1:0]    r_sig_e;
    logic [ACC_W-1:0]    r_noise_e;
    logic                r_det;
    logic                r_rv;
    logic                r_noise_ok;
    logic                r_ran_noise;
    logic                w_acc;
    logic                w_last;
    logic                w_pv;
    logic                w_ptag;
    logic [PW-1:0]       w_prod;
    logic [ACC_W-1:0]    w_add_n;
    logic [ACC_W-1:0]    w_add_s;
    logic [CW-1:0]       w_lhs;
    logic [CW-1:0]       w_rhs;

    assign sample_ready  = (r_state == NOISE) || (r_state == SIG);
    assign w_acc         = sample_valid && sample_ready;
    assign w_last        = w_acc && (&r_cnt);
    assign busy          = !((r_state == NOISE) && (r_cnt == '0));
    assign signal_energy = r_sig_e;
    assign noise_energy  = r_noise_e;
    assign detect        = r_det;
    assign result_valid  = r_rv;

    square_mag #(.DATA_W(DATA_W)) u_sq (
        .clk     (clk),
        .rst     (aclr),
        .i_valid (w_acc),
        .i_tag   (r_state == SIG),
        .i_re    (sample_real),
        .i_im    (sample_imag),
        .o_valid (w_pv),
        .o_tag   (w_ptag),
        .o_prod  (w_prod)
    );

    assign w_add_n = ACC_W'(sat_add(64'(r_noise_acc), 64'(w_prod), ACC_W));
    assign w_add_s = ACC_W'(sat_add(64'(r_sig_acc), 64'(w_prod), ACC_W));
    // both sides widened so neither the shift nor the product can truncate
    assign w_lhs   = CW'(r_sig_acc) << THR_FRAC;
    assign w_rhs   = CW'(r_noise_e) * CW'(thres);

    always_ff @(posedge clk) begin
        if (aclr) r_state <= NOISE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            NOISE:   w_next = w_last ? SIG : NOISE;
            SIG:     w_next = w_last ? DRAIN : SIG;
            DRAIN:   w_next = CMP;
            default: w_next = (hold_noise && r_noise_ok) ? SIG : NOISE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_cnt       <= '0;
            r_noise_acc <= '0;
            r_sig_acc   <= '0;
            r_sig_e     <= '0;
            r_noise_e   <= '0;
            r_det       <= 1'b0;
            r_rv        <= 1'b0;
            r_noise_ok  <= 1'b0;
            r_ran_noise <= 1'b0;
        end else begin
            r_rv <= (r_state == CMP);
            if (w_acc) r_cnt <= r_cnt + 1'b1;
            if (w_pv && !w_ptag) r_noise_acc <= w_add_n;
            if (w_pv && w_ptag) r_sig_acc <= w_add_s;
            if ((r_state == NOISE) && w_last) r_ran_noise <= 1'b1;
            if (r_state == DRAIN) begin
                if (r_ran_noise) r_noise_e <= r_noise_acc;
                r_noise_ok <= 1'b1;
            end
            if (r_state == CMP) begin
                r_det       <= w_lhs > w_rhs;
                r_sig_e     <= r_sig_acc;
                r_noise_acc <= '0;
                r_sig_acc   <= '0;
                r_ran_noise <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_energy_detector.sv
// tb_energy_detector: table-driven and randomized rounds against a window-sum model.
module tb_energy_detector;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              aclr = 1'b1;
    logic              sample_valid = 1'b0;
    logic              hold_noise = 1'b0;
    logic signed [7:0] sample_real = '0;
    logic signed [7:0] sample_imag = '0;
    logic [11:0]       thres = '0;
    logic              sample_ready;
    logic [15:0]       signal_energy;
    logic [15:0]       noise_energy;
    logic              detect;
    logic              result_valid;
    logic              busy;

    always #5 clk = ~clk;

    energy_detector #(.DATA_W(8), .ACC_W(16), .WIN_LOG2(2), .THR_W(12), .THR_FRAC(4)) dut (
        .clk           (clk),
        .aclr          (aclr),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_real   (sample_real),
        .sample_imag   (sample_imag),
        .thres         (thres),
        .hold_noise    (hold_noise),
        .signal_energy (signal_energy),
        .noise_energy  (noise_energy),
        .detect        (detect),
        .result_valid  (result_valid),
        .busy          (busy)
    );

    typedef struct {
        int nr, ni, sr, si, thr;
        bit hold, gap;
        int e_noise, e_sig;
        bit e_det;
    } vec_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;
    int     acc_tot = 0;
    int     nr_tot = 0;
    int     dbl = 0;
    bit     prev_rv = 0;

    longint m_noise = 0;
    bit     m_ok = 0;
    bit     m_hold = 0;
    longint last_pulse = 0;
    bit     have_prev = 0;
    int     nre[N], nim[N], sre[N], sim[N];
    vec_t   tbl[11];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sample_valid && sample_ready) acc_tot++;
        if (!sample_ready) nr_tot++;
        if (result_valid && prev_rv) dbl++;
        prev_rv = result_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat(input longint v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic push(input int re, input int im, input bit gap);
        int w = 0;
        if (gap) begin
            sample_valid = 1'b0;
            tick;
        end
        sample_valid = 1'b1;
        sample_real  = 8'(re);
        sample_imag  = 8'(im);
        while (!sample_ready && w < 40) begin
            tick;
            w++;
        end
        if (!sample_ready) chk("ready_timeout", sample_ready, 1);
        tick;
        sample_valid = 1'b0;
    endtask

    task automatic run_round(input string name, input int thr, input bit hold, input bit gap,
                             input bit use_tbl, input int e_noise, input int e_sig, input bit e_det);
        longint ns = 0;
        longint ss = 0;
        longint sig_m;
        bit     det_m;
        int     lat;
        bit     run_noise;
        int     a0 = acc_tot;
        int     r0 = nr_tot;
        run_noise  = !(m_hold && m_ok);
        thres      = 12'(thr);
        hold_noise = hold;
        if (run_noise)
            for (int i = 0; i < N; i++) begin
                push(nre[i], nim[i], gap);
                ns += nre[i] * nre[i] + nim[i] * nim[i];
            end
        for (int i = 0; i < N; i++) begin
            push(sre[i], sim[i], gap);
            ss += sre[i] * sre[i] + sim[i] * sim[i];
        end
        lat = 1;
        while (!result_valid && lat < 12) begin
            tick;
            lat++;
        end
        chk({name, "_latency"}, lat, 3);
        if (run_noise) m_noise = sat(ns);
        m_ok   = 1;
        m_hold = hold;
        sig_m  = sat(ss);
        det_m  = (sig_m * 16) > (m_noise * thr);
        chk({name, "_signal"}, signal_energy, use_tbl ? e_sig : sig_m);
        chk({name, "_noise"}, noise_energy, use_tbl ? e_noise : m_noise);
        chk({name, "_detect"}, detect, use_tbl ? e_det : det_m);
        chk({name, "_accepts"}, acc_tot - a0, run_noise ? 2 * N : N);
        chk({name, "_notready"}, nr_tot - r0, 2);
        if (have_prev && !gap) chk({name, "_spacing"}, cyc - last_pulse, run_noise ? 2 * N + 2 : N + 2);
        chk({name, "_single_pulse"}, dbl, 0);
        last_pulse = cyc;
        have_prev  = 1;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        for (int i = 0; i < N; i++) begin
            nre[i] = v.nr;
            nim[i] = v.ni;
            sre[i] = v.sr;
            sim[i] = v.si;
        end
        run_round(name, v.thr, v.hold, v.gap, 1, v.e_noise, v.e_sig, v.e_det);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 3, 4, 32, 0, 0, 8, 100, 1};
        tbl[1]  = '{1, 1, 2, 0, 32, 0, 0, 8, 16, 0};
        tbl[2]  = '{0, 0, -128, -128, 32, 0, 0, 0, 65535, 1};
        tbl[3]  = '{0, 0, 0, 0, 32, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 3, 4, 32, 1, 0, 8, 100, 1};
        tbl[5]  = '{9, 9, 3, 4, 32, 1, 0, 8, 100, 1};
        tbl[6]  = '{9, 9, 2, 0, 16, 0, 1, 8, 16, 1};
        tbl[7]  = '{5, -3, 1, 0, 4095, 0, 0, 136, 4, 0};
        tbl[8]  = '{10, 10, 20, 20, 64, 0, 0, 800, 3200, 0};
        tbl[9]  = '{2, 1, 3, 4, 32, 1, 0, 20, 100, 1};
        tbl[10] = '{9, 9, 1, 1, 8, 0, 0, 20, 8, 0};

        tick;
        tick;
        chk("reset_signal", signal_energy, 0);
        chk("reset_noise", noise_energy, 0);
        chk("reset_detect", detect, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", sample_ready, 1);
        aclr = 1'b0;

        for (int k = 0; k < 9; k++) run_vec($sformatf("vec%0d", k), tbl[k]);

        for (int i = 0; i < N; i++) push(1, 1, 0);
        push(3, 4, 0);
        push(3, 4, 0);
        chk("mid_busy", busy, 1);
        hold_noise = 1'b1;
        aclr = 1'b1;
        tick;
        aclr = 1'b0;
        chk("mid_reset_signal", signal_energy, 0);
        chk("mid_reset_noise", noise_energy, 0);
        chk("mid_reset_detect", detect, 0);
        chk("mid_reset_rv", result_valid, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_ready", sample_ready, 1);
        m_ok      = 0;
        m_hold    = 1;
        have_prev = 0;
        run_vec("post_reset", tbl[9]);
        run_vec("post_reset_hold", tbl[10]);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                nre[i] = int'($urandom_range(0, 255)) - 128;
                nim[i] = int'($urandom_range(0, 255)) - 128;
                sre[i] = int'($urandom_range(0, 255)) - 128;
                sim[i] = int'($urandom_range(0, 255)) - 128;
                if (r % 3 == 0) begin
                    sre[i] = sre[i] / 16;
                    sim[i] = sim[i] / 16;
                end
            end
            run_round($sformatf("rnd%0d", r), int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), 0, 0, 0, 0);
        end

        chk("no_double_pulse", dbl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
